// File: rtl/pb_input_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, per-bit debounce FSM, optional
// sticky press latch cleared by processor reads, and a registered output.
module pb_input_conditioner #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       sticky_mode,
    input  logic       rd_strobe,
    output logic [3:0] pushbuttons,
    output logic [3:0] btn_level,
    output logic       press_pending,
    output logic [7:0] dbg_state
);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 16'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [3:0]           sync1_q, sync2_q;
    state_e               state_q [4];
    state_e               state_d [4];
    logic [CNT_WIDTH-1:0] cnt_q   [4];
    logic [CNT_WIDTH-1:0] cnt_d   [4];
    logic [3:0]           level;
    logic [3:0]           level_prev_q;
    logic [3:0]           rise;
    logic [3:0]           sticky_q, sticky_d;
    logic [3:0]           pb_q, pb_d;
    logic                 pending_q, pending_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Counter restarts at 1 on the first opposite sample, so reaching
    // CNT_LAST means the new level was seen for DEBOUNCE_CYCLES samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_LOW: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_RISE;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                S_RISE: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_HIGH;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_FALL;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                S_FALL: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_LOW;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = S_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= S_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            level[i] = (state_q[i] == S_HIGH) || (state_q[i] == S_FALL);
        end
    end

    // A rise coincident with rd_strobe wins, so no press is ever lost.
    assign rise      = level & ~level_prev_q;
    assign sticky_d  = (sticky_q & ~{4{rd_strobe}}) | rise;
    assign pb_d      = sticky_mode ? sticky_q : level;
    assign pending_d = |sticky_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_prev_q <= '0;
            sticky_q     <= '0;
            pb_q         <= '0;
            pending_q    <= 1'b0;
        end else begin
            level_prev_q <= level;
            sticky_q     <= sticky_d;
            pb_q         <= pb_d;
            pending_q    <= pending_d;
        end
    end

    assign pushbuttons   = pb_q;
    assign btn_level     = level;
    assign press_pending = pending_q;
    assign dbg_state     = {state_q[3], state_q[2], state_q[1], state_q[0]};

endmodule

// File: doc/pb_input_conditioner.md
Name: pb_input_conditioner

Overview:
- Conditions the four raw, asynchronous pushbutton inputs before they reach the processor's 4-bit `pushbuttons` input port.
- Path: 2-flop synchronizer, then a per-bit debounce state machine, then an optional sticky press latch that clears when the processor executes an input read.
- Output is registered and glitch-free, so an IN instruction samples stable data.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive clk cycles a synchronized level must persist before it is accepted. Legal range 2..65535.
- CNT_WIDTH, 16: width of each per-bit debounce counter. Must hold DEBOUNCE_CYCLES-1.

Ports:
- clk, input, 1: system clock, same clock as the processor.
- reset, input, 1: asynchronous, active-high; clears all state.
- btn_raw, input, 4: raw pushbutton levels, asynchronous to clk; 1 = pressed.
- sticky_mode, input, 1: 0 = output debounced level; 1 = output latched presses.
- rd_strobe, input, 1: high for the clk cycle in which the processor's input buffer drives the data bus.
- pushbuttons, output, 4: conditioned value presented to the processor input buffer.
- btn_level, output, 4: debounced level of each button, regardless of mode.
- press_pending, output, 1: OR of the four sticky bits.

Behaviour:
- Reset (async, active-high):
  - Synchronizer flops, counters and sticky bits are all 0.
  - Every debounce FSM is in S_LOW.
  - pushbuttons = 4'b0000, btn_level = 4'b0000, press_pending = 0.
  - Reset asserted mid-count abandons the count; after release the FSM restarts from S_LOW.
- Synchronizer: two flops per bit (sync1 <= btn_raw, sync2 <= sync1). No logic between them.
- Per-bit FSM, four states, counter cnt:
  - S_LOW: level=0. If sync2=1, go to S_RISE and set cnt=1.
  - S_RISE: level=0.
    - If sync2=0, return to S_LOW with cnt=0 (bounce rejected).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to S_HIGH with cnt=0.
    - Else cnt++.
  - S_HIGH: level=1. If sync2=0, go to S_FALL and set cnt=1.
  - S_FALL: level=1.
    - If sync2=1, return to S_HIGH with cnt=0.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to S_LOW with cnt=0.
    - Else cnt++.
- Timing: a level held for exactly DEBOUNCE_CYCLES cycles at sync2 is accepted. One cycle shorter is rejected.
- Latency: a clean raw edge appears on btn_level DEBOUNCE_CYCLES+2 clk edges after the first sampling edge.
- The counter never wraps: it saturates by the state change at the terminal count.
- btn_level[i] is registered: 1 in S_HIGH and S_FALL, 0 otherwise.
- Sticky latch: rise[i] = 1 for one cycle when btn_level[i] goes 0 -> 1 (registered previous level).
- Sticky update at each edge: sticky[i] <= (sticky[i] & ~rd_strobe) | rise[i].
  - A rise coincident with rd_strobe leaves the bit set, so no press is lost.
  - A press that occurs while the bit is already set is merged, not counted.
- Output: pushbuttons is a register loaded every cycle with sticky_mode ? sticky : btn_level.
  - It lags its source by 1 cycle.
  - It is constant during a cycle, so a read always sees one coherent 4-bit value.
- Clear-on-read visibility: rd_strobe in cycle N samples the pre-clear value. sticky clears at the end of N, and pushbuttons shows the cleared value in cycle N+2.
- sticky_mode toggling takes effect on pushbuttons one cycle later. Sticky bits keep accumulating in both modes.
- press_pending is registered: OR of sticky.
- Independence: all four bits are fully independent. Simultaneous presses on several bits each debounce on their own.

Test Plan (DEBOUNCE_CYCLES=8):
- Reset: assert reset with btn_raw=4'hF -> pushbuttons=0, btn_level=0, press_pending=0 throughout. After release with btn_raw held at 4'hF, btn_level=4'hF exactly 10 clk edges later.
- Bounce rejection: btn_raw[0] high for 7 cycles, low 3, high 7 -> btn_level[0] stays 0. Then hold high 8 cycles -> btn_level[0]=1.
- Release debounce: from btn_level[2]=1, glitch btn_raw[2] low for 5 cycles -> btn_level[2] stays 1. A sustained low clears it after 8+2 edges.
- Sticky clear-on-read: sticky_mode=1, press and release button 1 -> pushbuttons=4'b0010, press_pending=1. Pulse rd_strobe 1 cycle -> pushbuttons=4'b0000 two cycles later.
- Simultaneous set/clear: rise on button 3 in the same cycle as rd_strobe while sticky=4'b0001 -> sticky becomes 4'b1000 (bit 0 cleared, bit 3 kept).
- Mid-operation reset: assert reset while button 0 is at cnt=5 in S_RISE -> all outputs 0 immediately. After release, a full 8 cycles is needed to accept the press.
